// File: rtl/wfid_rr_picker.sv
// Round-robin picker over 8 wavefront slots. Produces a held, registered
// 3-bit wfid grant with a valid/accept handshake and an accepted-pick counter.
module wfid_rr_picker #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             req,
    input  logic                   halt,
    input  logic                   pick_accept,
    output logic                   pick_valid,
    output logic [2:0]             pick_wfid,
    output logic [COUNT_WIDTH-1:0] pick_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]             r_state;
    logic [2:0]             r_wfid;
    logic [2:0]             r_last_ptr;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [7:0]             w_cand;
    logic [2:0]             w_base;
    logic                   w_found;
    logic [2:0]             w_idx;
    logic [0:0]             w_state_nxt;
    logic [2:0]             w_wfid_nxt;
    logic [2:0]             w_last_nxt;
    logic [COUNT_WIDTH-1:0] w_count_nxt;

    // First set bit of cand scanning upward from last+1 with wrap; MSB of result = found.
    function automatic logic [3:0] rr_search(input logic [7:0] cand, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 8; k >= 1; k--) begin
            idx = last + k[2:0];
            if (cand[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Candidate set: while holding, the granted slot is excluded and the scan starts after it.
    always_comb begin
        w_cand = req;
        w_base = r_last_ptr;
        if (r_state == ST_HOLD) begin
            w_cand[r_wfid] = 1'b0;
            w_base         = r_wfid;
        end else begin
            w_base = r_last_ptr;
        end
    end

    assign {w_found, w_idx} = rr_search(w_cand, w_base);

    // Next-state and grant selection.
    always_comb begin
        w_state_nxt = r_state;
        w_wfid_nxt  = r_wfid;
        w_last_nxt  = r_last_ptr;
        w_count_nxt = r_count;
        case (r_state)
            ST_EMPTY: begin
                if (!halt && w_found) begin
                    w_state_nxt = ST_HOLD;
                    w_wfid_nxt  = w_idx;
                    w_last_nxt  = w_idx;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (pick_accept) begin
                    w_count_nxt = r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                    w_last_nxt  = r_wfid;
                    if (!halt && w_found) begin
                        w_wfid_nxt = w_idx;
                        w_last_nxt = w_idx;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State registers; reset points last_ptr at 7 so the first scan starts at slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_wfid     <= 3'd0;
            r_last_ptr <= 3'd7;
            r_count    <= {COUNT_WIDTH{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_wfid     <= w_wfid_nxt;
            r_last_ptr <= w_last_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign pick_valid = r_state[0];
    assign pick_wfid  = r_wfid;
    assign pick_count = r_count;

endmodule

// File: tb/tb_wfid_rr_picker.sv
// Bench for wfid_rr_picker: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by a slot-order reference model.
`timescale 1ns/1ps
module tb_wfid_rr_picker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req = 8'h00;
    logic        halt = 1'b0;
    logic        pick_accept = 1'b0;
    logic        pick_valid, pick_valid4;
    logic [2:0]  pick_wfid, pick_wfid4;
    logic [15:0] pick_count;
    logic [3:0]  pick_count4;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    int m_valid = 0;
    int m_wfid = 0;
    int m_last = 7;
    int m_count = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    wfid_rr_picker #(.COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .halt(halt), .pick_accept(pick_accept),
        .pick_valid(pick_valid), .pick_wfid(pick_wfid), .pick_count(pick_count)
    );

    wfid_rr_picker #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .halt(halt), .pick_accept(pick_accept),
        .pick_valid(pick_valid4), .pick_wfid(pick_wfid4), .pick_count(pick_count4)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Slot order after 'last': last+1, last+2, ... modulo 8.
    function automatic int rr_pick(input logic [7:0] cand, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (cand[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    // Reference model: advances on each edge and queues every grant it issues.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 0; m_wfid = 0; m_last = 7; m_count = 0;
                exp_q.delete();
            end else if (m_valid == 0) begin
                if (!halt && req != 8'h00) begin
                    m_wfid = rr_pick(req, m_last);
                    m_last = m_wfid;
                    m_valid = 1;
                    exp_q.push_back(m_wfid);
                end
            end else if (pick_accept) begin
                logic [7:0] cand;
                int s;
                m_count = (m_count + 1) % 65536;
                m_last = m_wfid;
                cand = req;
                cand[m_wfid] = 1'b0;
                s = rr_pick(cand, m_last);
                if (!halt && s >= 0) begin
                    m_wfid = s;
                    m_last = s;
                    exp_q.push_back(s);
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    // Monitor: compares presented outputs against the model and retires accepted grants.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("valid", {31'd0, pick_valid}, m_valid);
                chk("count", {16'd0, pick_count}, m_count);
                chk("count4", {28'd0, pick_count4}, m_count % 16);
                if (pick_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL grant_queue: got wfid %0d with no expected grant", pick_wfid);
                    end else begin
                        chk("wfid", {29'd0, pick_wfid}, exp_q[0]);
                        if (pick_accept) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic [7:0] r, input logic h, input logic a);
        req = r; halt = h; pick_accept = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00; halt = 1'b0; pick_accept = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, pick_valid}, 32'd0);
        chk("rst_wfid", {29'd0, pick_wfid}, 32'd0);
        chk("rst_count", {16'd0, pick_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // first grant latency and hold stability
        step(8'h00, 1'b0, 1'b0);
        chk("idle_valid", {31'd0, pick_valid}, 32'd0);
        step(8'b0010_0100, 1'b0, 1'b0);
        chk("first_valid", {31'd0, pick_valid}, 32'd1);
        chk("first_wfid", {29'd0, pick_wfid}, 32'd2);
        step(8'h80, 1'b0, 1'b0);
        chk("hold_wfid", {29'd0, pick_wfid}, 32'd2);

        // fairness sweep with all slots requesting
        do_reset();
        step(8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("sweep_wfid", {29'd0, pick_wfid}, k % 8);
            step(8'hFF, 1'b0, 1'b1);
        end
        chk("sweep_count", {16'd0, pick_count}, 32'd10);

        // wrap past 7 with the held slot excluded
        step(8'h40, 1'b0, 1'b1);
        chk("to6_wfid", {29'd0, pick_wfid}, 32'd6);
        step(8'b0100_0001, 1'b0, 1'b1);
        chk("wrap_wfid", {29'd0, pick_wfid}, 32'd0);
        step(8'b0100_0000, 1'b0, 1'b1);
        chk("back6_wfid", {29'd0, pick_wfid}, 32'd6);

        // halt while holding, then accepts while empty
        step(8'h08, 1'b0, 1'b1);
        chk("to3_wfid", {29'd0, pick_wfid}, 32'd3);
        step(8'hFF, 1'b1, 1'b0);
        chk("halt_hold_valid", {31'd0, pick_valid}, 32'd1);
        chk("halt_hold_wfid", {29'd0, pick_wfid}, 32'd3);
        step(8'hFF, 1'b1, 1'b1);
        chk("halt_drop_valid", {31'd0, pick_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(8'hFF, 1'b1, 1'b1);
            chk("empty_valid", {31'd0, pick_valid}, 32'd0);
            chk("empty_count", {16'd0, pick_count}, 32'd15);
        end

        // narrow counter wrap at 16 accepts
        step(8'hFF, 1'b0, 1'b0);
        chk("resume_wfid", {29'd0, pick_wfid}, 32'd4);
        step(8'hFF, 1'b0, 1'b1);
        chk("count4_wrap", {28'd0, pick_count4}, 32'd0);
        chk("count16_val", {16'd0, pick_count}, 32'd16);
        chk("pre_rst_wfid", {29'd0, pick_wfid}, 32'd5);

        // async reset mid-cycle while holding
        pick_accept = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, pick_valid}, 32'd0);
        chk("async_wfid", {29'd0, pick_wfid}, 32'd0);
        chk("async_count", {16'd0, pick_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'hFF, 1'b0, 1'b0);
        chk("post_rst_wfid", {29'd0, pick_wfid}, 32'd0);

        // random traffic checked by the scoreboard
        for (int k = 0; k < 400; k++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step(r, ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
